// File: rtl/pipe_pkg.sv
// Shared constants and payload type for the pipeline-stage registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;
   localparam int PIPE_N  = 32;
   localparam int PIPE_CW = 16;
   localparam logic [PIPE_N-1:0] PIPE_NOP = '0;

   typedef logic [PIPE_N-1:0] pipe_word_t;
endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// Latency: n/a (wires only).
// Backpressure: carries ready in both directions; slave is the stage side.
interface pipe_stage_skid_if #(
   parameter int N  = 32,
   parameter int CW = 16
);
   logic          flush_i;
   logic          valid_i;
   logic          ready_o;
   logic [N-1:0]  data_i;
   logic          valid_o;
   logic          ready_i;
   logic [N-1:0]  data_o;
   logic          cnt_clr_i;
   logic [CW-1:0] stall_cnt_o;

   modport slave (
      input  flush_i, valid_i, data_i, ready_i, cnt_clr_i,
      output ready_o, valid_o, data_o, stall_cnt_o
   );

   modport master (
      output flush_i, valid_i, data_i, ready_i, cnt_clr_i,
      input  ready_o, valid_o, data_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_stall_counter.sv
// Saturating event counter with synchronous clear for stall monitoring.
// Latency: count reflects an event one cycle after it occurs.
// Backpressure: none; sticks at all-ones instead of wrapping.
module pipe_stall_counter #(
   parameter int CW = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt
);

   // Clear beats increment; increment stops at the all-ones value.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CW{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with optional 1-entry skid buffer, flush and stall counter.
// Latency: 1 cycle from input acceptance to data_o when the stage is empty or draining.
// Backpressure: SKID=1 registers ready_o (skid absorbs one beat); SKID=0 passes ready_i combinationally.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int           N    = PIPE_N,
   parameter int           SKID = 1,
   parameter logic [N-1:0] NOP  = '0,
   parameter int           CW   = PIPE_CW
) (
   input  logic CLK,
   input  logic RST,
   pipe_stage_skid_if.slave bus
);

   logic         main_v, main_v_nxt;
   logic [N-1:0] main_d, main_d_nxt;
   logic         skid_v, skid_v_nxt;
   logic [N-1:0] skid_d, skid_d_nxt;
   logic         ready;
   logic         in_fire;
   logic         out_fire;
   logic         main_free;

   // With a skid, ready depends only on skid occupancy, so no ready_i path reaches ready_o.
   assign ready     = (SKID != 0) ? !skid_v : (bus.ready_i | !main_v);
   assign in_fire   = bus.valid_i & ready;
   assign out_fire  = main_v & bus.ready_i;
   assign main_free = !main_v | out_fire;

   assign bus.ready_o = ready;
   assign bus.valid_o = main_v;
   assign bus.data_o  = main_v ? main_d : NOP;

   // Next-state: drain skid into main first to keep FIFO order; flush overrides everything.
   always_comb begin
      main_v_nxt = main_v;
      main_d_nxt = main_d;
      skid_v_nxt = skid_v;
      skid_d_nxt = skid_d;
      if (main_free) begin
         if (skid_v) begin
            main_v_nxt = 1'b1;
            main_d_nxt = skid_d;
            skid_v_nxt = in_fire;
            if (in_fire) begin
               skid_d_nxt = bus.data_i;
            end
         end else if (in_fire) begin
            main_v_nxt = 1'b1;
            main_d_nxt = bus.data_i;
         end else begin
            main_v_nxt = 1'b0;
            main_d_nxt = NOP;
         end
      end else if (in_fire && (SKID != 0)) begin
         skid_v_nxt = 1'b1;
         skid_d_nxt = bus.data_i;
      end
      if (bus.flush_i) begin
         main_v_nxt = 1'b0;
         main_d_nxt = NOP;
         skid_v_nxt = 1'b0;
      end
   end

   // State registers; the skid pair stays constant-empty when SKID=0 and trims away.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         main_v <= 1'b0;
         main_d <= NOP;
         skid_v <= 1'b0;
         skid_d <= NOP;
      end else begin
         main_v <= main_v_nxt;
         main_d <= main_d_nxt;
         skid_v <= skid_v_nxt;
         skid_d <= skid_d_nxt;
      end
   end

   pipe_stall_counter #(.CW(CW)) u_stall_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (main_v & !bus.ready_i),
      .clr (bus.cnt_clr_i),
      .cnt (bus.stall_cnt_o)
   );

endmodule
